latch_bist: RTL and testbench

LATCH_BIST -- requirements
Module: latch_bist

---
 rtl/latch_bist_if.sv | 37 +++
 rtl/latch_bist.sv | 162 ++++++++++++++++
 tb/tb_latch_bist.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/latch_bist_if.sv
// Handshake and latch-drive bundle between the latch BIST controller and its host/DUT side.
// LATCH_BIST_FAIL_LOG_EN adds the first-failure log signals.
interface latch_bist_if;
  logic       start;
  logic       lat_q;
  logic       lat_q_not;
  logic       lat_d;
  logic       lat_enable;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
`ifdef LATCH_BIST_FAIL_LOG_EN
  logic       fail_valid;
  logic [2:0] first_fail_step;

  modport master (
    output start, lat_q, lat_q_not,
    input  lat_d, lat_enable, busy, done, pass, err_count,
    input  fail_valid, first_fail_step
  );
  modport slave (
    input  start, lat_q, lat_q_not,
    output lat_d, lat_enable, busy, done, pass, err_count,
    output fail_valid, first_fail_step
  );
`else
  modport master (
    output start, lat_q, lat_q_not,
    input  lat_d, lat_enable, busy, done, pass, err_count
  );
  modport slave (
    input  start, lat_q, lat_q_not,
    output lat_d, lat_enable, busy, done, pass, err_count
  );
`endif
endinterface

// File: rtl/latch_bist.sv
// Built-in self test for a single D latch: walks an 8-step enable/d table and counts q/q_not mismatches.
// Optional first-failure log enabled by defining LATCH_BIST_FAIL_LOG_EN.
//
// state  | meaning
// IDLE   | waiting for start; results held
// DRIVE  | lat_enable applied for the current step (d untouched)
// SETTLE | lat_d applied, held SETTLE_CYCLES cycles
// CHECK  | compare lat_q/lat_q_not against expected q
// FINISH | publish pass, pulse done next cycle, return to IDLE
module latch_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic        clk,
  input logic        reset,
  latch_bist_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Step tables, bit i belongs to step i.
  localparam logic [7:0] TBL_EN = 8'b0101_0011;
  localparam logic [7:0] TBL_D  = 8'b0110_1010;
  localparam logic [7:0] TBL_Q  = 8'b1100_1110;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] ERR_MAX     = 4'd8;

  state_t     state, state_nxt;
  logic [2:0] step, step_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       en_r, en_nxt;
  logic       d_r, d_nxt;
  logic       busy_r, busy_nxt;
  logic       done_r, done_nxt;
  logic       pass_r, pass_nxt;
  logic [3:0] err_r, err_nxt;
  logic [2:0] step_inc;
  logic       step_fail;
`ifdef LATCH_BIST_FAIL_LOG_EN
  logic       fv_r, fv_nxt;
  logic [2:0] ff_r, ff_nxt;
`endif

  assign step_inc  = step + 3'd1;
  assign step_fail = (bus.lat_q != TBL_Q[step]) || (bus.lat_q_not != ~TBL_Q[step]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      step   <= 3'd0;
      cnt    <= 4'd0;
      en_r   <= 1'b0;
      d_r    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
      err_r  <= 4'd0;
`ifdef LATCH_BIST_FAIL_LOG_EN
      fv_r   <= 1'b0;
      ff_r   <= 3'd0;
`endif
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      cnt    <= cnt_nxt;
      en_r   <= en_nxt;
      d_r    <= d_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      pass_r <= pass_nxt;
      err_r  <= err_nxt;
`ifdef LATCH_BIST_FAIL_LOG_EN
      fv_r   <= fv_nxt;
      ff_r   <= ff_nxt;
`endif
    end
  end

  // Drives are registered on entry to DRIVE/SETTLE so enable always moves a cycle before d.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    cnt_nxt   = cnt;
    en_nxt    = en_r;
    d_nxt     = d_r;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    pass_nxt  = pass_r;
    err_nxt   = err_r;
`ifdef LATCH_BIST_FAIL_LOG_EN
    fv_nxt    = fv_r;
    ff_nxt    = ff_r;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = DRIVE;
          step_nxt  = 3'd0;
          err_nxt   = 4'd0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          en_nxt    = TBL_EN[0];
`ifdef LATCH_BIST_FAIL_LOG_EN
          fv_nxt    = 1'b0;
          ff_nxt    = 3'd0;
`endif
        end
      end
      DRIVE: begin
        state_nxt = SETTLE;
        cnt_nxt   = SETTLE_LOAD;
        d_nxt     = TBL_D[step];
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nxt = CHECK;
        else             cnt_nxt   = cnt - 4'd1;
      end
      CHECK: begin
        if (step_fail) begin
          if (err_r != ERR_MAX) err_nxt = err_r + 4'd1;
`ifdef LATCH_BIST_FAIL_LOG_EN
          if (!fv_r) begin
            fv_nxt = 1'b1;
            ff_nxt = step;
          end
`endif
        end
        if (step == 3'd7) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = DRIVE;
          step_nxt  = step_inc;
          en_nxt    = TBL_EN[step_inc];
        end
      end
      FINISH: begin
        done_nxt  = 1'b1;
        pass_nxt  = (err_r == 4'd0);
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.lat_enable = en_r;
  assign bus.lat_d      = d_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.err_count  = err_r;
`ifdef LATCH_BIST_FAIL_LOG_EN
  assign bus.fail_valid      = fv_r;
  assign bus.first_fail_step = ff_r;
`endif

endmodule

// File: tb/tb_latch_bist.sv
// Self-checking bench for latch_bist: latch models selected per vector, scoreboard of pass results,
// per-cycle drive ordering model, reset abort sequence.
module tb_latch_bist;

  localparam int SC  = 2;
  localparam int PER = SC + 2;
  localparam int LAT = 8 * PER + 1;

  logic clk = 1'b0;
  logic reset;
  int   mode;
  logic q_lat;
  int   checks = 0;
  int   errors = 0;

  latch_bist_if bus();

  latch_bist #(.SETTLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ideal level-sensitive latch.
  initial q_lat = 1'b0;
  always @(bus.lat_enable or bus.lat_d) if (bus.lat_enable) q_lat = bus.lat_d;

  always_comb begin
    bus.lat_q     = q_lat;
    bus.lat_q_not = ~q_lat;
    case (mode)
      1: begin bus.lat_q = 1'b0;       bus.lat_q_not = 1'b1;        end
      2: begin bus.lat_q = bus.lat_d;  bus.lat_q_not = ~bus.lat_d;  end
      3: begin bus.lat_q = q_lat;      bus.lat_q_not = q_lat;       end
      default: ;
    endcase
  end

  typedef struct {
    int         mode;
    bit         poke;
    bit         e_pass;
    logic [3:0] e_err;
    bit         e_fv;
    logic [2:0] e_ff;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];

  bit step_en[8] = '{1, 1, 0, 0, 1, 0, 1, 0};
  bit step_d[8]  = '{0, 1, 0, 1, 0, 1, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lat_d"}, int'(bus.lat_d), 0);
    chk({tag, "_lat_enable"}, int'(bus.lat_enable), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_pass"}, int'(bus.pass), 0);
    chk({tag, "_err_count"}, int'(bus.err_count), 0);
`ifdef LATCH_BIST_FAIL_LOG_EN
    chk({tag, "_fail_valid"}, int'(bus.fail_valid), 0);
    chk({tag, "_first_fail_step"}, int'(bus.first_fail_step), 0);
`endif
  endtask

  task automatic run_pass(input vec_t v);
    int   k;
    bit   got;
    int   s;
    int   p;
    bit   e_d;
    bit   saw;
    vec_t e;
    mode = v.mode;
    @(negedge clk);
    bus.start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    bus.start = 1'b0;
    k   = 0;
    got = 0;
    while (k < 100 && !got) begin
      if (bus.done) begin
        got = 1;
      end else begin
        if (k == 0) begin
          chk("pass_cleared_on_start", int'(bus.pass), 0);
          chk("err_cleared_on_start", int'(bus.err_count), 0);
        end
        if (k < 8 * PER) begin
          s   = k / PER;
          p   = k % PER;
          e_d = (p >= 1) ? step_d[s] : ((s > 0) ? step_d[s - 1] : 1'b0);
          chk($sformatf("lat_enable_k%0d", k), int'(bus.lat_enable), int'(step_en[s]));
          chk($sformatf("lat_d_k%0d", k), int'(bus.lat_d), int'(e_d));
        end
        chk($sformatf("busy_k%0d", k), int'(bus.busy), 1);
        bus.start = (v.poke && k == 10);
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
    chk("done_latency", got ? k : -1, LAT);
    e = sb.pop_front();
    chk("pass", int'(bus.pass), int'(e.e_pass));
    chk("err_count", int'(bus.err_count), int'(e.e_err));
    chk("busy_at_done", int'(bus.busy), 0);
`ifdef LATCH_BIST_FAIL_LOG_EN
    chk("fail_valid", int'(bus.fail_valid), int'(e.e_fv));
    chk("first_fail_step", int'(bus.first_fail_step), int'(e.e_ff));
`endif
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
    chk("pass_held", int'(bus.pass), int'(e.e_pass));
    chk("err_held", int'(bus.err_count), int'(e.e_err));
    if (v.poke) begin
      saw = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy) saw = 1;
      end
      chk("busy_start_ignored", int'(saw), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  saw;
    vec_t rv;
    vecs[0] = '{mode: 0, poke: 0, e_pass: 1, e_err: 4'd0, e_fv: 0, e_ff: 3'd0};
    vecs[1] = '{mode: 1, poke: 0, e_pass: 0, e_err: 4'd5, e_fv: 1, e_ff: 3'd1};
    vecs[2] = '{mode: 2, poke: 0, e_pass: 0, e_err: 4'd3, e_fv: 1, e_ff: 3'd2};
    vecs[3] = '{mode: 3, poke: 0, e_pass: 0, e_err: 4'd8, e_fv: 1, e_ff: 3'd0};
    vecs[4] = '{mode: 0, poke: 1, e_pass: 1, e_err: 4'd0, e_fv: 0, e_ff: 3'd0};

    mode      = 0;
    reset     = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_pass(vecs[i]);

    // Abort during step 4, with start held high across the reset.
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (k < 4 * PER + 1) begin
      @(negedge clk);
      k++;
    end
    chk("busy_before_abort", int'(bus.busy), 1);
    reset     = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    @(negedge clk);
    chk_reset_vals("abort_hold");
    reset     = 1'b0;
    bus.start = 1'b0;
    saw = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw = 1;
    end
    chk("no_done_after_abort", int'(saw), 0);
    rv = '{mode: 0, poke: 0, e_pass: 1, e_err: 4'd0, e_fv: 0, e_ff: 3'd0};
    run_pass(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
